// File: rtl/lif_post_neuron_if.sv
// Signal bundle between the spike source / STDP learning side (master) and lif_post_neuron (slave).
// Carries pre-synaptic spikes, the weight-load path and the neuron's registered outputs.
interface lif_post_neuron_if #(
    parameter int unsigned NUM_PRE = 4,
    parameter int unsigned W_WIDTH = 4,
    parameter int unsigned V_WIDTH = 8
);
    logic [NUM_PRE-1:0]         pre_spike;
    logic [NUM_PRE*W_WIDTH-1:0] weight_in;
    logic                       weight_load;
    logic                       post_spike;
    logic [V_WIDTH-1:0]         membrane;
    logic                       refractory;
    logic [7:0]                 spike_count;

    modport master (
        output pre_spike,
        output weight_in,
        output weight_load,
        input  post_spike,
        input  membrane,
        input  refractory,
        input  spike_count
    );

    modport slave (
        input  pre_spike,
        input  weight_in,
        input  weight_load,
        output post_spike,
        output membrane,
        output refractory,
        output spike_count
    );
endinterface

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire post-synaptic neuron with refractory period and loadable weights.
// Define LIF_LEAK_EN to apply the v >> LEAK_SHIFT leak; otherwise it is a pure integrator.
module lif_post_neuron #(
    parameter int unsigned NUM_PRE       = 4,
    parameter int unsigned W_WIDTH       = 4,
    parameter int unsigned V_WIDTH       = 8,
    parameter int unsigned THRESHOLD     = 16,
    parameter int unsigned LEAK_SHIFT    = 2,
    parameter int unsigned REFRAC_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    lif_post_neuron_if.slave bus
);

    localparam int unsigned S_WIDTH = W_WIDTH + $clog2(NUM_PRE) + 1;
    localparam int unsigned A_WIDTH = ((V_WIDTH > S_WIDTH) ? V_WIDTH : S_WIDTH) + 1;
    localparam int unsigned R_WIDTH = $clog2(REFRAC_CYCLES + 2);
    localparam logic [V_WIDTH-1:0] V_MAX = {V_WIDTH{1'b1}};
    localparam logic [V_WIDTH-1:0] V_THR = V_WIDTH'(THRESHOLD);

`ifdef LIF_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        StIntegrate,
        StRefractory
    } state_e;

    state_e                          r_state;
    state_e                          w_state_d;
    logic [NUM_PRE-1:0][W_WIDTH-1:0] r_weight;
    logic [V_WIDTH-1:0]              r_membrane;
    logic [V_WIDTH-1:0]              w_membrane_d;
    logic                            r_post;
    logic                            w_post_d;
    logic                            r_refractory;
    logic [7:0]                      r_count;
    logic [7:0]                      w_count_d;
    logic [R_WIDTH-1:0]              r_rcnt;
    logic [R_WIDTH-1:0]              w_rcnt_d;

    logic [S_WIDTH-1:0]              w_sum;
    logic [V_WIDTH-1:0]              w_leak;
    logic [V_WIDTH-1:0]              w_decay;
    logic [A_WIDTH-1:0]              w_acc;
    logic [V_WIDTH-1:0]              w_v_next;
    logic                            w_fire;

    // Weights in use this edge are the registered ones; a load only affects later edges.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (bus.pre_spike[i]) begin
                w_sum = w_sum + S_WIDTH'(r_weight[i]);
            end
        end
    end

    assign w_leak   = LEAK_EN ? (r_membrane >> LEAK_SHIFT) : '0;
    assign w_decay  = r_membrane - w_leak;
    assign w_acc    = A_WIDTH'(w_decay) + A_WIDTH'(w_sum);
    assign w_v_next = (w_acc > A_WIDTH'(V_MAX)) ? V_MAX : w_acc[V_WIDTH-1:0];
    assign w_fire   = (w_v_next >= V_THR);

    always_comb begin
        w_state_d    = r_state;
        w_membrane_d = r_membrane;
        w_post_d     = 1'b0;
        w_count_d    = r_count;
        w_rcnt_d     = r_rcnt;
        unique case (r_state)
            StIntegrate: begin
                if (w_fire) begin
                    w_membrane_d = '0;
                    w_post_d     = 1'b1;
                    w_count_d    = r_count + 8'd1;
                    if (REFRAC_CYCLES > 0) begin
                        w_rcnt_d  = R_WIDTH'(REFRAC_CYCLES);
                        w_state_d = StRefractory;
                    end
                end else begin
                    w_membrane_d = w_v_next;
                end
            end
            StRefractory: begin
                // Inputs and leak are ignored; the potential is pinned at zero.
                w_membrane_d = '0;
                w_rcnt_d     = r_rcnt - R_WIDTH'(1);
                if (r_rcnt == R_WIDTH'(1)) begin
                    w_state_d = StIntegrate;
                end
            end
            default: begin
                w_state_d = StIntegrate;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIntegrate;
            r_membrane   <= '0;
            r_post       <= 1'b0;
            r_refractory <= 1'b0;
            r_count      <= '0;
            r_rcnt       <= '0;
        end else begin
            r_state      <= w_state_d;
            r_membrane   <= w_membrane_d;
            r_post       <= w_post_d;
            r_refractory <= (w_state_d == StRefractory);
            r_count      <= w_count_d;
            r_rcnt       <= w_rcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= '0;
        end else if (bus.weight_load) begin
            r_weight <= bus.weight_in;
        end
    end

    assign bus.post_spike  = r_post;
    assign bus.membrane    = r_membrane;
    assign bus.refractory  = r_refractory;
    assign bus.spike_count = r_count;

endmodule

// File: tb/tb_lif_post_neuron.sv
// Self-checking bench for lif_post_neuron: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural neuron model.
module tb_lif_post_neuron;

`ifdef LIF_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_post_neuron_if #(.NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8)) if_a ();
    lif_post_neuron_if #(.NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8)) if_b ();

    lif_post_neuron #(
        .NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8), .THRESHOLD(16), .LEAK_SHIFT(2), .REFRAC_CYCLES(3)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    lif_post_neuron #(
        .NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8), .THRESHOLD(16), .LEAK_SHIFT(2), .REFRAC_CYCLES(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // Neuron as the rules describe it: potential, cycles of refractory left, fire count, weights.
    typedef struct packed {
        int          v;
        int          rl;
        int          cnt;
        bit          spk;
        logic [15:0] w;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;
    int n_pass  = 0;
    int n_total = 0;

    function automatic model_t step(model_t m, logic [3:0] pre, logic ld, logic [15:0] win,
                                    int rc);
        model_t n;
        int sum;
        int leak;
        int vn;
        n = m;
        if (m.rl > 0) begin
            n.v   = 0;
            n.spk = 1'b0;
            n.rl  = m.rl - 1;
        end else begin
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                if (pre[i]) sum += int'(m.w[i*4 +: 4]);
            end
            leak = LEAK ? (m.v / 4) : 0;
            vn   = m.v - leak + sum;
            if (vn > 255) vn = 255;
            if (vn >= 16) begin
                n.v   = 0;
                n.spk = 1'b1;
                n.cnt = (m.cnt + 1) % 256;
                n.rl  = rc;
            end else begin
                n.v   = vn;
                n.spk = 1'b0;
            end
        end
        if (ld) n.w = win;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, if_a.pre_spike, if_a.weight_load, if_a.weight_in, 3);
            mb <= step(mb, if_b.pre_spike, if_b.weight_load, if_b.weight_in, 0);
        end
    end

    always @(negedge clk) begin
        chk("a_post_spike",  int'(if_a.post_spike),  int'(ma.spk));
        chk("a_membrane",    int'(if_a.membrane),    ma.v);
        chk("a_refractory",  int'(if_a.refractory),  int'(ma.rl > 0));
        chk("a_spike_count", int'(if_a.spike_count), ma.cnt);
        chk("b_post_spike",  int'(if_b.post_spike),  int'(mb.spk));
        chk("b_membrane",    int'(if_b.membrane),    mb.v);
        chk("b_refractory",  int'(if_b.refractory),  int'(mb.rl > 0));
        chk("b_spike_count", int'(if_b.spike_count), mb.cnt);
    end

    // Called at a falling edge; returns at the next one, when the edge's result is visible.
    task automatic tick_a(input logic [3:0] pre, input logic ld, input logic [15:0] w);
        if_a.pre_spike   = pre;
        if_a.weight_load = ld;
        if_a.weight_in   = w;
        @(negedge clk);
    endtask

    task automatic tick_b(input logic [3:0] pre, input logic ld, input logic [15:0] w);
        if_b.pre_spike   = pre;
        if_b.weight_load = ld;
        if_b.weight_in   = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        if_a.pre_spike   = '0;
        if_a.weight_load = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq[$];
        if_a.pre_spike = '0; if_a.weight_load = 1'b0; if_a.weight_in = '0;
        if_b.pre_spike = '0; if_b.weight_load = 1'b0; if_b.weight_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_membrane", int'(if_a.membrane), 0);
        chk("rst_count",    int'(if_a.spike_count), 0);
        rst_n = 1'b1;

        // Load all 15, one 4'b1111 pulse fires; 3 refractory cycles mask further input.
        tick_a(4'h0, 1'b1, 16'hFFFF);
        tick_a(4'hF, 1'b0, 16'h0000);
        chk("fire_post", int'(if_a.post_spike), 1);
        chk("fire_mem",  int'(if_a.membrane), 0);
        chk("fire_cnt",  int'(if_a.spike_count), 1);
        chk("fire_refr", int'(if_a.refractory), 1);
        for (int i = 0; i < 3; i++) begin
            tick_a(4'hF, 1'b0, 16'h0000);
            chk("mask_mem",  int'(if_a.membrane), 0);
            chk("mask_post", int'(if_a.post_spike), 0);
            chk("mask_refr", int'(if_a.refractory), (i < 2) ? 1 : 0);
        end
        tick_a(4'hF, 1'b0, 16'h0000);
        chk("refire_post", int'(if_a.post_spike), 1);
        chk("refire_cnt",  int'(if_a.spike_count), 2);
        repeat (3) tick_a(4'h0, 1'b0, 16'h0000);

        // Integration of w0=5 held on input 0.
        do_reset();
        tick_a(4'h0, 1'b1, 16'h0005);
`ifdef LIF_LEAK_EN
        exp_seq = '{5, 9, 12, 14};
`else
        exp_seq = '{5, 10, 15};
`endif
        foreach (exp_seq[i]) begin
            tick_a(4'h1, 1'b0, 16'h0000);
            chk("integ_mem", int'(if_a.membrane), exp_seq[i]);
        end
        tick_a(4'h1, 1'b0, 16'h0000);
        chk("integ_fire", int'(if_a.post_spike), 1);
        repeat (3) tick_a(4'h0, 1'b0, 16'h0000);

        // Decay from 12 with no input.
        do_reset();
        tick_a(4'h0, 1'b1, 16'h000C);
        tick_a(4'h1, 1'b0, 16'h0000);
        chk("decay_start", int'(if_a.membrane), 12);
`ifdef LIF_LEAK_EN
        exp_seq = '{9, 7, 6, 5, 4, 3, 3};
`else
        exp_seq = '{12, 12, 12, 12, 12, 12, 12};
`endif
        foreach (exp_seq[i]) begin
            tick_a(4'h0, 1'b0, 16'h0000);
            chk("decay_mem", int'(if_a.membrane), exp_seq[i]);
        end

        // Load and spike on the same edge: the old weight is integrated.
        do_reset();
        tick_a(4'h0, 1'b1, 16'h1111);
        tick_a(4'h1, 1'b1, 16'hFFFF);
        chk("coll_mem", int'(if_a.membrane), 1);
        tick_a(4'h1, 1'b0, 16'h0000);
        chk("coll_fire", int'(if_a.post_spike), 1);
        chk("coll_mem0", int'(if_a.membrane), 0);

        // Asynchronous reset in the middle of refractory.
        tick_a(4'h0, 1'b0, 16'h0000);
        chk("pre_rst_refr", int'(if_a.refractory), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_post", int'(if_a.post_spike), 0);
        chk("arst_mem",  int'(if_a.membrane), 0);
        chk("arst_refr", int'(if_a.refractory), 0);
        chk("arst_cnt",  int'(if_a.spike_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_a(4'h0, 1'b1, 16'h0003);
        tick_a(4'h1, 1'b0, 16'h0000);
        chk("post_rst_integ", int'(if_a.membrane), 3);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            tick_a(4'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        // Zero-length refractory: fires every cycle and the count wraps.
        tick_b(4'h0, 1'b1, 16'hFFFF);
        for (int i = 1; i <= 256; i++) begin
            tick_b(4'hF, 1'b0, 16'h0000);
            if (i == 255) chk("wrap_255", int'(if_b.spike_count), 255);
        end
        chk("wrap_0",    int'(if_b.spike_count), 0);
        chk("wrap_post", int'(if_b.post_spike), 1);
        tick_b(4'h0, 1'b0, 16'h0000);
        chk("b_drop", int'(if_b.post_spike), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
